// File: rtl/demux_pkg.sv
// demux_pkg: shared widths, FSM state encoding and illegal-select threshold
// for the demux5_buf slice.
package demux_pkg;

   localparam int unsigned DW          = 16;  // data width
   localparam int unsigned NOUT        = 5;   // destination count
   localparam int unsigned SW          = 3;   // select width
   localparam int unsigned ILLEGAL_SEL = 5;   // selects at or above this are illegal

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage : demux_pkg

// File: rtl/demux5_buf_sel_decode5.sv
// sel_decode5: combinational select decoder.
//   sel     in  [SW-1:0]   destination index
//   onehot  out [NOUT-1:0] one-hot destination, all zero when illegal
//   illegal out            select is outside the destination range
module sel_decode5
   import demux_pkg::*;
(
   input  logic [SW-1:0]   sel,
   output logic [NOUT-1:0] onehot,
   output logic            illegal
);

   always_comb begin
      onehot  = '0;
      illegal = (sel >= SW'(ILLEGAL_SEL));
      for (int unsigned i = 0; i < NOUT; i++) begin
         if (sel == SW'(i)) onehot[i] = 1'b1;
      end
   end

endmodule : sel_decode5

// File: rtl/demux5_buf.sv
// demux5_buf: single-entry buffered 1-to-5 demultiplexer with valid/ready
// handshakes on both sides.
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data/in_sel    word and destination offered by the source
//   in_valid/in_ready source handshake; transfer = in_valid & in_ready
//   out1..out5        held word, driven identically on all five ports
//   out_valid         one-hot: destination holding an undelivered word
//   out_ready         per-destination accept
//   err/err_clr       sticky illegal-select flag and its synchronous clear
//   xfer_cnt          wrapping count of completed deliveries
module demux5_buf
   import demux_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [DW-1:0]   in_data,
   input  logic [SW-1:0]   in_sel,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [DW-1:0]   out1,
   output logic [DW-1:0]   out2,
   output logic [DW-1:0]   out3,
   output logic [DW-1:0]   out4,
   output logic [DW-1:0]   out5,
   output logic [NOUT-1:0] out_valid,
   input  logic [NOUT-1:0] out_ready,
   output logic            err,
   input  logic            err_clr,
   output logic [7:0]      xfer_cnt
);

   state_t            state_q, state_d;
   logic [DW-1:0]     buf_q, buf_d;
   logic [NOUT-1:0]   tgt_q, tgt_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              err_q, err_d;

   logic [NOUT-1:0]   dec_onehot;
   logic              dec_illegal;
   logic              delivery;
   logic              xfer;

   sel_decode5 u_dec (
      .sel     (in_sel),
      .onehot  (dec_onehot),
      .illegal (dec_illegal)
   );

   // tgt_q is one-hot whenever FULL, so masking with it ignores the
   // out_ready bits of every non-targeted destination.
   always_comb begin
      out_valid = (state_q == FULL) ? tgt_q : '0;
      delivery  = |(out_valid & out_ready);
      in_ready  = (state_q == EMPTY) | delivery;
      xfer      = in_valid & in_ready;
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      if (delivery) begin
         state_d = EMPTY;
         cnt_d   = cnt_q + 8'd1;
      end

      // A legal capture overrides the drain, giving back-to-back throughput.
      // An illegal one is swallowed: buffer and target keep their contents.
      if (xfer && !dec_illegal) begin
         state_d = FULL;
         buf_d   = in_data;
         tgt_d   = dec_onehot;
      end

      if (xfer && dec_illegal) err_d = 1'b1;
      else if (err_clr)        err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         buf_q   <= '0;
         tgt_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign out1     = buf_q;
   assign out2     = buf_q;
   assign out3     = buf_q;
   assign out4     = buf_q;
   assign out5     = buf_q;
   assign err      = err_q;
   assign xfer_cnt = cnt_q;

endmodule : demux5_buf

// File: tb/tb_demux5_buf.sv
module tb_demux5_buf;

   logic        clk;
   logic        rst_n;
   logic [15:0] in_data;
   logic [2:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out1, out2, out3, out4, out5;
   logic [4:0]  out_valid;
   logic [4:0]  out_ready;
   logic        err;
   logic        err_clr;
   logic [7:0]  xfer_cnt;

   logic [15:0] outs [5];
   assign outs[0] = out1;
   assign outs[1] = out2;
   assign outs[2] = out3;
   assign outs[3] = out4;
   assign outs[4] = out5;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   demux5_buf dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .out4      (out4),
      .out5      (out5),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err),
      .err_clr   (err_clr),
      .xfer_cnt  (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [2:0]  sel;
      logic [15:0] d;
      logic [4:0]  ordy;
      logic        clr;
      logic        ir;    // in_ready before the edge
      logic [4:0]  ov;    // out_valid after the edge
      logic [15:0] dat;   // out1..out5 after the edge
      logic        e;     // err after the edge
      logic [7:0]  cnt;   // xfer_cnt after the edge
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string name, input logic [15:0] exp);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("%s out%0d", name, k + 1), {16'h0, outs[k]}, {16'h0, exp});
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] sel, input logic [15:0] d,
                        input logic [4:0] ordy, input logic clr);
      in_valid  = v;
      in_sel    = sel;
      in_data   = d;
      out_ready = ordy;
      err_clr   = clr;
   endtask

   initial begin
      //             v    sel   data     ordy   clr  | ir   ov     dat      e     cnt
      vq.push_back('{1'b1, 3'd0, 16'hABCD, 5'h00, 1'b0, 1'b1, 5'h01, 16'hABCD, 1'b0, 8'd0});
      vq.push_back('{1'b0, 3'd0, 16'h0000, 5'h00, 1'b0, 1'b0, 5'h01, 16'hABCD, 1'b0, 8'd0});
      vq.push_back('{1'b0, 3'd0, 16'h0000, 5'h01, 1'b0, 1'b1, 5'h00, 16'hABCD, 1'b0, 8'd1});
      vq.push_back('{1'b1, 3'd1, 16'h0123, 5'h1F, 1'b0, 1'b1, 5'h02, 16'h0123, 1'b0, 8'd1});
      vq.push_back('{1'b1, 3'd2, 16'h0000, 5'h1F, 1'b0, 1'b1, 5'h04, 16'h0000, 1'b0, 8'd2});
      vq.push_back('{1'b1, 3'd3, 16'h4567, 5'h1F, 1'b0, 1'b1, 5'h08, 16'h4567, 1'b0, 8'd3});
      vq.push_back('{1'b1, 3'd4, 16'h89EF, 5'h1F, 1'b0, 1'b1, 5'h10, 16'h89EF, 1'b0, 8'd4});
      vq.push_back('{1'b0, 3'd0, 16'h0000, 5'h1F, 1'b0, 1'b1, 5'h00, 16'h89EF, 1'b0, 8'd5});
      vq.push_back('{1'b1, 3'd2, 16'hABCD, 5'h1B, 1'b0, 1'b1, 5'h04, 16'hABCD, 1'b0, 8'd5});
      vq.push_back('{1'b0, 3'd0, 16'h0000, 5'h1B, 1'b0, 1'b0, 5'h04, 16'hABCD, 1'b0, 8'd5});
      vq.push_back('{1'b1, 3'd0, 16'h1111, 5'h1B, 1'b0, 1'b0, 5'h04, 16'hABCD, 1'b0, 8'd5});
      vq.push_back('{1'b0, 3'd0, 16'h0000, 5'h1B, 1'b0, 1'b0, 5'h04, 16'hABCD, 1'b0, 8'd5});
      vq.push_back('{1'b0, 3'd0, 16'h0000, 5'h1B, 1'b0, 1'b0, 5'h04, 16'hABCD, 1'b0, 8'd5});
      vq.push_back('{1'b0, 3'd0, 16'h0000, 5'h1F, 1'b0, 1'b1, 5'h00, 16'hABCD, 1'b0, 8'd6});
      vq.push_back('{1'b1, 3'd6, 16'h1234, 5'h00, 1'b0, 1'b1, 5'h00, 16'hABCD, 1'b1, 8'd6});
      vq.push_back('{1'b0, 3'd0, 16'h0000, 5'h00, 1'b1, 1'b1, 5'h00, 16'hABCD, 1'b0, 8'd6});
      vq.push_back('{1'b1, 3'd7, 16'h1234, 5'h00, 1'b1, 1'b1, 5'h00, 16'hABCD, 1'b1, 8'd6});
      vq.push_back('{1'b0, 3'd0, 16'h0000, 5'h00, 1'b1, 1'b1, 5'h00, 16'hABCD, 1'b0, 8'd6});
      vq.push_back('{1'b1, 3'd0, 16'h5555, 5'h00, 1'b0, 1'b1, 5'h01, 16'h5555, 1'b0, 8'd6});
      vq.push_back('{1'b1, 3'd5, 16'h9999, 5'h01, 1'b0, 1'b1, 5'h00, 16'h5555, 1'b1, 8'd7});
      vq.push_back('{1'b0, 3'd0, 16'h0000, 5'h00, 1'b1, 1'b1, 5'h00, 16'h5555, 1'b0, 8'd7});
      vq.push_back('{1'b1, 3'd3, 16'h0F0F, 5'h00, 1'b0, 1'b1, 5'h08, 16'h0F0F, 1'b0, 8'd7});
      vq.push_back('{1'b0, 3'd0, 16'h0000, 5'h17, 1'b0, 1'b0, 5'h08, 16'h0F0F, 1'b0, 8'd7});
      vq.push_back('{1'b0, 3'd0, 16'h0000, 5'h08, 1'b0, 1'b1, 5'h00, 16'h0F0F, 1'b0, 8'd8});

      // Reset state
      rst_n = 1'b0;
      drive(1'b0, 3'd0, 16'h0000, 5'h00, 1'b0);
      #3;
      check("rst out_valid", {27'h0, out_valid}, 32'h0);
      check_outs("rst", 16'h0000);
      check("rst err", {31'h0, err}, 32'h0);
      check("rst xfer_cnt", {24'h0, xfer_cnt}, 32'h0);
      check("rst in_ready", {31'h0, in_ready}, 32'h1);
      rst_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].v, vq[i].sel, vq[i].d, vq[i].ordy, vq[i].clr);
         #1;
         check($sformatf("v%0d in_ready", i), {31'h0, in_ready}, {31'h0, vq[i].ir});
         @(posedge clk);
         #1;
         check($sformatf("v%0d out_valid", i), {27'h0, out_valid}, {27'h0, vq[i].ov});
         check_outs($sformatf("v%0d", i), vq[i].dat);
         check($sformatf("v%0d err", i), {31'h0, err}, {31'h0, vq[i].e});
         check($sformatf("v%0d xfer_cnt", i), {24'h0, xfer_cnt}, {24'h0, vq[i].cnt});
      end

      // Mid-cycle asynchronous reset while FULL with err set
      drive(1'b1, 3'd7, 16'h2222, 5'h00, 1'b0);
      @(posedge clk); #1;
      drive(1'b1, 3'd4, 16'h89EF, 5'h00, 1'b0);
      @(posedge clk); #1;
      check("ar pre out_valid", {27'h0, out_valid}, 32'h10);
      check("ar pre out5", {16'h0, out5}, 32'h89EF);
      check("ar pre err", {31'h0, err}, 32'h1);
      drive(1'b0, 3'd0, 16'h0000, 5'h00, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar out_valid", {27'h0, out_valid}, 32'h0);
      check("ar out5", {16'h0, out5}, 32'h0);
      check("ar err", {31'h0, err}, 32'h0);
      check("ar xfer_cnt", {24'h0, xfer_cnt}, 32'h0);
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("ar release in_ready", {31'h0, in_ready}, 32'h1);
      check("ar release out_valid", {27'h0, out_valid}, 32'h0);

      // Counter wrap: first edge captures, each later edge delivers and reloads
      drive(1'b1, 3'd0, 16'h7777, 5'h01, 1'b0);
      repeat (256) @(posedge clk);
      #1;
      check("wrap cnt255", {24'h0, xfer_cnt}, 32'd255);
      check("wrap full", {27'h0, out_valid}, 32'h01);
      drive(1'b0, 3'd0, 16'h0000, 5'h01, 1'b0);
      @(posedge clk); #1;
      check("wrap cnt0", {24'h0, xfer_cnt}, 32'd0);
      check("wrap empty", {27'h0, out_valid}, 32'h0);
      check_outs("wrap hold", 16'h7777);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_demux5_buf
